// File: rtl/rob_defs.sv
// rtl/rob_defs.sv - shared ROB/RS type definitions used by the reservation station
package rob_defs;

    localparam int ROB_ID_W        = 6;
    localparam int RV_DATA_W       = 64;
    localparam int RS_PAYLOAD_W    = 64;
    localparam int RS_NUM_SRC      = 2;
    localparam int NUM_RS_WB_PORTS = 2;

    typedef logic [ROB_ID_W-1:0]  t_rob_id;
    typedef logic [RV_DATA_W-1:0] t_rv_reg_data;

    typedef struct packed {
        logic         rdy;
        t_rob_id      tag;
        t_rv_reg_data data;
    } t_rs_src;

    typedef struct packed {
        t_rob_id                     rob_id;
        logic [RS_PAYLOAD_W-1:0]     payload;
        t_rs_src [RS_NUM_SRC-1:0]    src;
    } t_rs_disp_pkt;

    typedef struct packed {
        t_rob_id                       rob_id;
        logic [RS_PAYLOAD_W-1:0]       payload;
        t_rv_reg_data [RS_NUM_SRC-1:0] src_data;
    } t_rs_iss_pkt;

    function automatic logic tag_hit(input logic vld, input t_rob_id a, input t_rob_id b);
        return vld && (a == b);
    endfunction

endpackage

// File: rtl/rs_age_mtx.sv
// rtl/rs_age_mtx.sv - age matrix picking the oldest requesting entry (one-hot grant)
module rs_age_mtx #(
    parameter int NUM_ENTS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ENTS-1:0] alloc_i,
    input  logic [NUM_ENTS-1:0] free_i,
    input  logic [NUM_ENTS-1:0] req_i,
    output logic [NUM_ENTS-1:0] gnt_o
);

    // age_q[r][c] = 1 means entry r is older than entry c
    logic [NUM_ENTS-1:0][NUM_ENTS-1:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        for (int r = 0; r < NUM_ENTS; r++) begin
            for (int c = 0; c < NUM_ENTS; c++) begin
                if (alloc_i[c] && (r != c)) begin
                    age_d[r][c] = 1'b1;
                end else if (alloc_i[r] || free_i[r]) begin
                    age_d[r][c] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < NUM_ENTS; i++) begin
            gnt_o[i] = req_i[i];
            for (int j = 0; j < NUM_ENTS; j++) begin
                if ((j != i) && req_i[j] && age_q[j][i]) begin
                    gnt_o[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rs_age_sched.sv
// rtl/rs_age_sched.sv - reservation station with wakeup, dispatch bypass and oldest-ready issue
module rs_age_sched
    import rob_defs::*;
#(
    parameter int NUM_ENTS  = 8,
    parameter int NUM_WB    = 2,
    parameter int NUM_SRC   = 2,
    parameter int PAYLOAD_W = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         disp_valid_rs0,
    input  t_rs_disp_pkt                 disp_pkt_rs0,
    output logic                         rs_stall_rs0,
    input  logic [NUM_WB-1:0]            wb_valid_rb0,
    input  t_rob_id [NUM_WB-1:0]         wb_rob_id_rb0,
    input  t_rv_reg_data [NUM_WB-1:0]    wb_data_rb0,
    output logic                         iss_rs1,
    output t_rs_iss_pkt                  iss_pkt_rs1,
    input  logic                         iss_stall_rs1,
    input  logic                         flush_rb1,
    output logic [$clog2(NUM_ENTS):0]    occupancy_rs0
);

    localparam int IDX_W = $clog2(NUM_ENTS);
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(NUM_ENTS);

    logic [NUM_ENTS-1:0]                      valid_q, valid_d;
    logic [NUM_ENTS-1:0][NUM_SRC-1:0]         rdy_q, rdy_d;
    t_rv_reg_data [NUM_ENTS-1:0][NUM_SRC-1:0] data_q, data_d;
    t_rob_id [NUM_ENTS-1:0][NUM_SRC-1:0]      tag_q;
    t_rob_id [NUM_ENTS-1:0]                   rob_q;
    logic [NUM_ENTS-1:0][PAYLOAD_W-1:0]       pay_q;
    logic [IDX_W:0]                           occ_q, occ_d;
    logic                                     iss_q, iss_d;
    t_rs_iss_pkt                              iss_pkt_q, iss_pkt_d, sel_pkt, dir_pkt;

    logic [NUM_ENTS-1:0]        req, gnt, alloc_oh, free_oh;
    logic [IDX_W-1:0]           free_idx;
    logic                       disp_acc, disp_all_rdy, hold, sel_en, dir_en, alloc_en;
    logic [NUM_SRC-1:0]         dsp_rdy;
    t_rv_reg_data [NUM_SRC-1:0] dsp_data;

    assign rs_stall_rs0  = (occ_q == FULL_CNT);
    assign occupancy_rs0 = occ_q;
    assign iss_rs1       = iss_q;
    assign iss_pkt_rs1   = iss_pkt_q;

    assign disp_acc = disp_valid_rs0 && !rs_stall_rs0 && !flush_rb1;
    assign hold     = iss_q && iss_stall_rs1;
    assign sel_en   = !hold && (|gnt);
    // A fully-ready dispatch skips the array only when nothing older is waiting to issue
    assign dir_en   = disp_acc && disp_all_rdy && !hold && !(|req);
    assign alloc_en = disp_acc && !dir_en;
    assign free_oh  = sel_en ? gnt : '0;

    always_comb begin
        free_idx = '0;
        for (int i = NUM_ENTS-1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
        for (int i = 0; i < NUM_ENTS; i++) begin
            alloc_oh[i] = alloc_en && (free_idx == IDX_W'(i));
            req[i]      = valid_q[i] && (&rdy_q[i]);
        end
    end

    // Wakeup of the incoming packet; descending scan leaves the lowest port as winner
    always_comb begin
        disp_all_rdy = 1'b1;
        for (int s = 0; s < NUM_SRC; s++) begin
            dsp_rdy[s]   = disp_pkt_rs0.src[s].rdy;
            dsp_data[s]  = disp_pkt_rs0.src[s].data;
            disp_all_rdy = disp_all_rdy && disp_pkt_rs0.src[s].rdy;
            if (!disp_pkt_rs0.src[s].rdy) begin
                for (int p = NUM_WB-1; p >= 0; p--) begin
                    if (tag_hit(wb_valid_rb0[p], wb_rob_id_rb0[p], disp_pkt_rs0.src[s].tag)) begin
                        dsp_rdy[s]  = 1'b1;
                        dsp_data[s] = wb_data_rb0[p];
                    end
                end
            end
        end
    end

    always_comb begin
        rdy_d  = rdy_q;
        data_d = data_q;
        for (int i = 0; i < NUM_ENTS; i++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (valid_q[i] && !rdy_q[i][s]) begin
                    for (int p = NUM_WB-1; p >= 0; p--) begin
                        if (tag_hit(wb_valid_rb0[p], wb_rob_id_rb0[p], tag_q[i][s])) begin
                            rdy_d[i][s]  = 1'b1;
                            data_d[i][s] = wb_data_rb0[p];
                        end
                    end
                end
            end
        end
        if (alloc_en) begin
            rdy_d[free_idx]  = dsp_rdy;
            data_d[free_idx] = dsp_data;
        end
    end

    always_comb begin
        sel_pkt = '0;
        for (int i = 0; i < NUM_ENTS; i++) begin
            if (gnt[i]) begin
                sel_pkt.rob_id  = rob_q[i];
                sel_pkt.payload = pay_q[i];
                for (int s = 0; s < NUM_SRC; s++) sel_pkt.src_data[s] = data_q[i][s];
            end
        end
        dir_pkt.rob_id  = disp_pkt_rs0.rob_id;
        dir_pkt.payload = disp_pkt_rs0.payload;
        for (int s = 0; s < NUM_SRC; s++) dir_pkt.src_data[s] = disp_pkt_rs0.src[s].data;
    end

    always_comb begin
        valid_d   = (valid_q & ~free_oh) | alloc_oh;
        occ_d     = occ_q;
        iss_d     = iss_q;
        iss_pkt_d = iss_pkt_q;
        if (alloc_en && !sel_en) occ_d = occ_q + 1'b1;
        if (sel_en && !alloc_en) occ_d = occ_q - 1'b1;
        if (!hold) begin
            iss_d = sel_en || dir_en;
            if (sel_en)      iss_pkt_d = sel_pkt;
            else if (dir_en) iss_pkt_d = dir_pkt;
        end
        if (flush_rb1) begin
            valid_d = '0;
            occ_d   = '0;
            iss_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            rdy_q   <= '0;
            occ_q   <= '0;
            iss_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rdy_q   <= rdy_d;
            occ_q   <= occ_d;
            iss_q   <= iss_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q    <= data_d;
        iss_pkt_q <= iss_pkt_d;
        if (alloc_en) begin
            rob_q[free_idx] <= disp_pkt_rs0.rob_id;
            pay_q[free_idx] <= disp_pkt_rs0.payload;
            for (int s = 0; s < NUM_SRC; s++) tag_q[free_idx][s] <= disp_pkt_rs0.src[s].tag;
        end
    end

    rs_age_mtx #(
        .NUM_ENTS (NUM_ENTS)
    ) u_age_mtx (
        .clk     (clk),
        .reset   (reset),
        .alloc_i (alloc_oh),
        .free_i  (free_oh),
        .req_i   (req),
        .gnt_o   (gnt)
    );

endmodule

// File: tb/tb_rs_age_sched.sv
// tb/tb_rs_age_sched.sv - directed self-checking bench for rs_age_sched
module tb_rs_age_sched;
    import rob_defs::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  disp_valid_rs0;
    t_rs_disp_pkt          disp_pkt_rs0;
    logic                  rs_stall_rs0;
    logic [1:0]            wb_valid_rb0;
    t_rob_id [1:0]         wb_rob_id_rb0;
    t_rv_reg_data [1:0]    wb_data_rb0;
    logic                  iss_rs1;
    t_rs_iss_pkt           iss_pkt_rs1;
    logic                  iss_stall_rs1;
    logic                  flush_rb1;
    logic [3:0]            occupancy_rs0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rs_age_sched #(
        .NUM_ENTS  (8),
        .NUM_WB    (2),
        .NUM_SRC   (2),
        .PAYLOAD_W (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .disp_valid_rs0 (disp_valid_rs0),
        .disp_pkt_rs0   (disp_pkt_rs0),
        .rs_stall_rs0   (rs_stall_rs0),
        .wb_valid_rb0   (wb_valid_rb0),
        .wb_rob_id_rb0  (wb_rob_id_rb0),
        .wb_data_rb0    (wb_data_rb0),
        .iss_rs1        (iss_rs1),
        .iss_pkt_rs1    (iss_pkt_rs1),
        .iss_stall_rs1  (iss_stall_rs1),
        .flush_rb1      (flush_rb1),
        .occupancy_rs0  (occupancy_rs0)
    );

    typedef struct {
        int          rob;
        logic [63:0] pay;
        logic [63:0] d0;
        logic [63:0] d1;
        int          e_rob;
        logic [63:0] e_pay;
        logic [63:0] e_d0;
        logic [63:0] e_d1;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic e_iss, input int e_rob,
                           input logic [63:0] e_d0, input logic [63:0] e_d1,
                           input int e_occ, input logic e_stall);
        cmp({name, ".iss"}, 64'(iss_rs1), 64'(e_iss));
        if (e_iss) begin
            cmp({name, ".rob"}, 64'(iss_pkt_rs1.rob_id), 64'(e_rob));
            cmp({name, ".d0"}, iss_pkt_rs1.src_data[0], e_d0);
            cmp({name, ".d1"}, iss_pkt_rs1.src_data[1], e_d1);
        end
        cmp({name, ".occ"}, 64'(occupancy_rs0), 64'(e_occ));
        cmp({name, ".stall"}, 64'(rs_stall_rs0), 64'(e_stall));
    endtask

    function automatic t_rs_disp_pkt mk(input int rob, input logic [63:0] pay,
                                        input logic r0, input int t0, input logic [63:0] d0,
                                        input logic r1, input int t1, input logic [63:0] d1);
        t_rs_disp_pkt p;
        p.rob_id      = t_rob_id'(rob);
        p.payload     = pay;
        p.src[0].rdy  = r0;
        p.src[0].tag  = t_rob_id'(t0);
        p.src[0].data = d0;
        p.src[1].rdy  = r1;
        p.src[1].tag  = t_rob_id'(t1);
        p.src[1].data = d1;
        return p;
    endfunction

    task automatic disp(input t_rs_disp_pkt p);
        disp_valid_rs0 = 1'b1;
        disp_pkt_rs0   = p;
    endtask

    task automatic idle();
        disp_valid_rs0 = 1'b0;
        wb_valid_rb0   = '0;
        flush_rb1      = 1'b0;
    endtask

    task automatic wb(input int port, input int tag, input logic [63:0] data);
        wb_valid_rb0[port]  = 1'b1;
        wb_rob_id_rb0[port] = t_rob_id'(tag);
        wb_data_rb0[port]   = data;
    endtask

    initial begin
        reset          = 1'b0;
        disp_valid_rs0 = 1'b0;
        disp_pkt_rs0   = '0;
        wb_valid_rb0   = '0;
        wb_rob_id_rb0  = '0;
        wb_data_rb0    = '0;
        iss_stall_rs1  = 1'b0;
        flush_rb1      = 1'b0;
        tick();
        tick();
        chk_out("reset", 1'b0, 0, 64'h0, 64'h0, 0, 1'b0);
        reset = 1'b1;

        // Fully-ready dispatches appear on issue the very next cycle
        vecs[0] = '{rob: 5,  pay: 64'hC0DE, d0: 64'h11, d1: 64'h22,
                    e_rob: 5,  e_pay: 64'hC0DE, e_d0: 64'h11, e_d1: 64'h22};
        vecs[1] = '{rob: 63, pay: 64'hFFFF_FFFF_FFFF_FFFF, d0: 64'h0, d1: 64'hFFFF_FFFF_FFFF_FFFF,
                    e_rob: 63, e_pay: 64'hFFFF_FFFF_FFFF_FFFF, e_d0: 64'h0, e_d1: 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2] = '{rob: 0,  pay: 64'h1, d0: 64'h8000_0000_0000_0000, d1: 64'h1,
                    e_rob: 0,  e_pay: 64'h1, e_d0: 64'h8000_0000_0000_0000, e_d1: 64'h1};
        vecs[3] = '{rob: 42, pay: 64'h1234_5678, d0: 64'hDEAD_BEEF, d1: 64'hCAFE,
                    e_rob: 42, e_pay: 64'h1234_5678, e_d0: 64'hDEAD_BEEF, e_d1: 64'hCAFE};
        for (int i = 0; i < 4; i++) begin
            disp(mk(vecs[i].rob, vecs[i].pay, 1'b1, 0, vecs[i].d0, 1'b1, 0, vecs[i].d1));
            tick();
            idle();
            chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].e_rob, vecs[i].e_d0, vecs[i].e_d1, 0, 1'b0);
            cmp($sformatf("vec%0d.pay", i), iss_pkt_rs1.payload, vecs[i].e_pay);
        end
        tick();
        chk_out("vec_idle", 1'b0, 0, 64'h0, 64'h0, 0, 1'b0);

        // Wakeup on port 1 gives issue two cycles later
        disp(mk(3, 64'h3, 1'b0, 7, 64'h0, 1'b1, 0, 64'h55));
        tick();
        idle();
        chk_out("wait_disp", 1'b0, 0, 64'h0, 64'h0, 1, 1'b0);
        wb(1, 7, 64'hABCD);
        tick();
        idle();
        chk_out("wake_t1", 1'b0, 0, 64'h0, 64'h0, 1, 1'b0);
        tick();
        chk_out("wake_t2", 1'b1, 3, 64'hABCD, 64'h55, 0, 1'b0);

        // Dispatch-cycle bypass with both ports matching: port 0 wins
        disp(mk(9, 64'h9, 1'b0, 20, 64'h0, 1'b1, 0, 64'h66));
        wb(0, 20, 64'h100);
        wb(1, 20, 64'h200);
        tick();
        idle();
        chk_out("byp_t1", 1'b0, 0, 64'h0, 64'h0, 1, 1'b0);
        tick();
        chk_out("byp_t2", 1'b1, 9, 64'h100, 64'h66, 0, 1'b0);

        // Fill all entries, drop the ninth, wake one
        for (int i = 0; i < 8; i++) begin
            disp(mk(10 + i, 64'h0, 1'b0, 30 + i, 64'h0, 1'b1, 0, 64'(i)));
            tick();
        end
        idle();
        chk_out("full", 1'b0, 0, 64'h0, 64'h0, 8, 1'b1);
        disp(mk(50, 64'h0, 1'b1, 0, 64'h50, 1'b1, 0, 64'h51));
        tick();
        idle();
        chk_out("drop9", 1'b0, 0, 64'h0, 64'h0, 8, 1'b1);
        wb(0, 33, 64'h333);
        tick();
        idle();
        chk_out("wake_full_t1", 1'b0, 0, 64'h0, 64'h0, 8, 1'b1);
        disp(mk(51, 64'h0, 1'b1, 0, 64'h60, 1'b1, 0, 64'h61));
        tick();
        idle();
        chk_out("wake_full_t2", 1'b1, 13, 64'h333, 64'h3, 7, 1'b0);
        flush_rb1 = 1'b1;
        tick();
        idle();
        chk_out("flush_full", 1'b0, 0, 64'h0, 64'h0, 0, 1'b0);

        // Entry 2 becomes older than a reallocated entry 0
        disp(mk(1, 64'h0, 1'b0, 40, 64'h0, 1'b1, 0, 64'hA1));
        tick();
        disp(mk(2, 64'h0, 1'b0, 41, 64'h0, 1'b1, 0, 64'hA2));
        tick();
        disp(mk(4, 64'h0, 1'b0, 42, 64'h0, 1'b1, 0, 64'hA4));
        tick();
        idle();
        chk_out("age_fill", 1'b0, 0, 64'h0, 64'h0, 3, 1'b0);
        wb(0, 40, 64'h400);
        tick();
        idle();
        chk_out("age_w1", 1'b0, 0, 64'h0, 64'h0, 3, 1'b0);
        tick();
        chk_out("age_a", 1'b1, 1, 64'h400, 64'hA1, 2, 1'b0);
        disp(mk(6, 64'h0, 1'b0, 43, 64'h0, 1'b1, 0, 64'hA6));
        tick();
        idle();
        chk_out("age_d", 1'b0, 0, 64'h0, 64'h0, 3, 1'b0);
        wb(0, 42, 64'h420);
        wb(1, 43, 64'h430);
        tick();
        idle();
        chk_out("age_w2", 1'b0, 0, 64'h0, 64'h0, 3, 1'b0);
        tick();
        chk_out("age_old", 1'b1, 4, 64'h420, 64'hA4, 2, 1'b0);
        tick();
        chk_out("age_young", 1'b1, 6, 64'h430, 64'hA6, 1, 1'b0);
        tick();
        chk_out("age_done", 1'b0, 0, 64'h0, 64'h0, 1, 1'b0);

        // Issue backpressure holds the packet for three cycles
        disp(mk(7, 64'h0, 1'b1, 0, 64'h77, 1'b1, 0, 64'h78));
        tick();
        idle();
        chk_out("direct", 1'b1, 7, 64'h77, 64'h78, 1, 1'b0);
        iss_stall_rs1 = 1'b1;
        disp(mk(8, 64'h0, 1'b1, 0, 64'h88, 1'b1, 0, 64'h89));
        tick();
        idle();
        chk_out("hold1", 1'b1, 7, 64'h77, 64'h78, 2, 1'b0);
        wb(0, 41, 64'h410);
        tick();
        idle();
        chk_out("hold2", 1'b1, 7, 64'h77, 64'h78, 2, 1'b0);
        tick();
        chk_out("hold3", 1'b1, 7, 64'h77, 64'h78, 2, 1'b0);
        iss_stall_rs1 = 1'b0;
        tick();
        chk_out("rel_b", 1'b1, 2, 64'h410, 64'hA2, 1, 1'b0);
        tick();
        chk_out("rel_f", 1'b1, 8, 64'h88, 64'h89, 0, 1'b0);
        tick();
        chk_out("rel_idle", 1'b0, 0, 64'h0, 64'h0, 0, 1'b0);

        // Flush with four waiting entries and a live issue; same-cycle dispatch dropped
        for (int i = 0; i < 4; i++) begin
            disp(mk(20 + i, 64'h0, 1'b0, 50 + i, 64'h0, 1'b1, 0, 64'h0));
            tick();
        end
        disp(mk(30, 64'h0, 1'b1, 0, 64'h300, 1'b1, 0, 64'h301));
        tick();
        idle();
        chk_out("pre_flush", 1'b1, 30, 64'h300, 64'h301, 4, 1'b0);
        flush_rb1 = 1'b1;
        disp(mk(31, 64'h0, 1'b1, 0, 64'h310, 1'b1, 0, 64'h311));
        tick();
        idle();
        chk_out("flush", 1'b0, 0, 64'h0, 64'h0, 0, 1'b0);
        tick();
        chk_out("flush_drop", 1'b0, 0, 64'h0, 64'h0, 0, 1'b0);

        // Reset while an issue is held
        disp(mk(40, 64'h0, 1'b0, 60, 64'h0, 1'b1, 0, 64'h0));
        tick();
        disp(mk(41, 64'h0, 1'b1, 0, 64'h41A, 1'b1, 0, 64'h41B));
        tick();
        idle();
        iss_stall_rs1 = 1'b1;
        chk_out("pre_rst", 1'b1, 41, 64'h41A, 64'h41B, 1, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk_out("mid_rst", 1'b0, 0, 64'h0, 64'h0, 0, 1'b0);
        iss_stall_rs1 = 1'b0;
        tick();
        chk_out("post_rst", 1'b0, 0, 64'h0, 64'h0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_age_sched.md
RS_AGE_SCHED -- requirements
Module: rs_age_sched

Interface
REQ-001 SHALL have parameter NUM_ENTS, default 8, the number of reservation-station entries (power of two, 2..32).
REQ-002 SHALL have parameter NUM_WB, default 2, the number of writeback/wakeup broadcast ports.
REQ-003 SHALL have parameter NUM_SRC, default 2, the number of source operands per entry.
REQ-004 SHALL have parameter PAYLOAD_W, default 64, the width of the opaque uop payload (decoded op fields).
REQ-005 SHALL have port clk  in  1  the single clock; all state on rising edge.
REQ-006 SHALL have port reset  in  1  reset, synchronous and active-low (0 = reset).
REQ-007 SHALL have port disp_valid_rs0  in  1  dispatch request.
REQ-008 SHALL have port disp_pkt_rs0  in  t_rs_disp_pkt  rob_id, payload, per-source rdy/tag(t_rob_id)/data(t_rv_reg_data).
REQ-009 SHALL have port rs_stall_rs0  out  1  RS full; dispatch not accepted.
REQ-010 SHALL have port wb_valid_rb0  in  NUM_WB  per-port result valid.
REQ-011 SHALL have port wb_rob_id_rb0  in  NUM_WB x t_rob_id  producing ROB id per port.
REQ-012 SHALL have port wb_data_rb0  in  NUM_WB x t_rv_reg_data  result data per port.
REQ-013 SHALL have port iss_rs1  out  1  issue valid.
REQ-014 SHALL have port iss_pkt_rs1  out  t_rs_iss_pkt  rob_id, payload, NUM_SRC source data.
REQ-015 SHALL have port iss_stall_rs1  in  1  downstream backpressure on issue.
REQ-016 SHALL have port flush_rb1  in  1  branch-mispredict flush.
REQ-017 SHALL have port occupancy_rs0  out  $clog2(NUM_ENTS)+1  count of valid entries.

Function
REQ-018 SHALL accept dispatch when disp_valid_rs0 && !rs_stall_rs0 && !flush_rb1, writing the lowest-index free entry at the next edge.
REQ-019 SHALL drive rs_stall_rs0 = (occupancy_rs0 == NUM_ENTS); an issue in the same cycle SHALL NOT relieve the stall combinationally.
REQ-020 SHALL, on wb_valid_rb0[p] with wb_rob_id_rb0[p] equal to a waiting source tag, capture wb_data_rb0[p] and set that source ready at the next edge.
REQ-021 SHALL apply the same tag match to sources of the packet being dispatched in that cycle (dispatch-cycle bypass), so no wakeup is lost.
REQ-022 SHALL, if several ports match one tag in a cycle, take the lowest-numbered port.
REQ-023 SHALL consider an entry ready only when all NUM_SRC sources are ready in registered state; a wakeup at cycle T allows issue at T+2 (iss_rs1 high).
REQ-024 SHALL allow a dispatch with all sources ready at cycle T to appear on iss_rs1 at T+1 at earliest.
REQ-025 SHALL select, among ready entries, the oldest by dispatch order (age matrix), independent of entry index.
REQ-026 SHALL register iss_rs1/iss_pkt_rs1 and free the selected entry at the same edge the output is loaded.
REQ-027 SHALL, while iss_rs1 && iss_stall_rs1, hold iss_pkt_rs1 stable and select no new entry.
REQ-028 SHALL, on flush_rb1, invalidate all entries and clear iss_rs1 at the next edge; a dispatch in that cycle is dropped.
REQ-029 SHALL update occupancy_rs0 as +1 on accepted dispatch, -1 on issue selection, net 0 when both occur.

Reset
REQ-030 SHALL, while reset==0 at an edge, clear all entry valid and ready bits, age matrix, iss_rs1=0, occupancy_rs0=0, rs_stall_rs0=0; iss_pkt_rs1 contents are don't-care.
REQ-031 SHALL, on reset mid-operation, discard all entries and any held issue packet without emitting iss_rs1.

Structure
REQ-032 SHALL place t_rs_disp_pkt, t_rs_iss_pkt and NUM_RS_WB_PORTS in the shared rob_defs package.
REQ-033 SHALL implement oldest-ready selection in one sub-module rs_age_mtx (NUM_ENTS x NUM_ENTS age bits, alloc/free/req in, one-hot grant out).

Verification
REQ-034 SHALL verify: dispatch rob_id 5, both srcs ready, data 0x11/0x22 at T -> iss_rs1 at T+1 with rob_id 5, data 0x11/0x22.
REQ-035 SHALL verify: dispatch rob_id 3 waiting on tag 7; wb port 1 rob_id 7 data 0xABCD at T -> iss_rs1 at T+2 with src0 data 0xABCD.
REQ-036 SHALL verify: fill 8 entries none ready -> rs_stall_rs0=1, occupancy 8; 9th dispatch dropped; wake one -> stall clears the cycle after issue.
REQ-037 SHALL verify: entries 2 (older) and 0 (younger) wake in same cycle -> entry 2 issues first, entry 0 next cycle.
REQ-038 SHALL verify: iss_stall_rs1 held 3 cycles -> iss_pkt_rs1 unchanged; flush_rb1 with 4 entries -> occupancy 0 and iss_rs1=0 next cycle.
